// File: rtl/epp_bram_reader.sv
// EPP data-read responder: serves acquisition BRAM bytes to the host,
// one byte per EPP read strobe, with a fill-bounded auto-increment pointer.
module epp_bram_reader #(
    parameter int          ADDR_W      = 12,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  EMPTY_BYTE  = 8'hFF
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              dataStb,
    input  logic              eppWrite,
    output logic              eppWait,
    output logic [7:0]        dataOut,
    output logic              dataOe,
    output logic [ADDR_W-1:0] busBramAddr,
    input  logic [7:0]        busBramIn,
    input  logic [ADDR_W:0]   wrCount,
    input  logic              rdRewind,
    output logic [ADDR_W:0]   rdCount,
    output logic              underflow,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        RELEASE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [SYNC_STAGES-1:0] stb_q;
    logic [SYNC_STAGES-1:0] wr_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   stb_prev_q;
    logic                   armed_q;
    logic                   stb_s;
    logic                   wr_s;
    logic                   stb_fall;

    state_t          state_q, state_d;
    logic [ADDR_W:0] rd_cnt_q, rd_cnt_d;
    logic            uf_q, uf_d;
    logic [7:0]      dout_q, dout_d;
    logic            noadv_q, noadv_d;
    logic            empty;

    assign stb_s = stb_q[SYNC_STAGES-1];
    assign wr_s  = wr_q[SYNC_STAGES-1];

    // Only arm after a genuinely sampled high, so a strobe held low
    // across reset cannot masquerade as a fresh falling edge.
    assign stb_fall = armed_q & stb_prev_q & ~stb_s;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stb_q      <= '1;
            wr_q       <= '1;
            vld_q      <= '0;
            stb_prev_q <= 1'b1;
            armed_q    <= 1'b0;
        end else begin
            stb_q      <= {stb_q[SYNC_STAGES-2:0], dataStb};
            wr_q       <= {wr_q[SYNC_STAGES-2:0], eppWrite};
            vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            stb_prev_q <= stb_s;
            armed_q    <= armed_q | (vld_q[SYNC_STAGES-1] & stb_s);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            uf_q     <= 1'b0;
            dout_q   <= 8'h00;
            noadv_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            uf_q     <= uf_d;
            dout_q   <= dout_d;
            noadv_q  <= noadv_d;
        end
    end

    assign empty = (rd_cnt_q >= wrCount);

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        uf_d     = uf_q;
        dout_d   = dout_q;
        noadv_d  = noadv_q;
        unique case (state_q)
            IDLE: begin
                if (stb_fall && wr_s) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = PRESENT;
                if (empty) begin
                    dout_d  = EMPTY_BYTE;
                    uf_d    = 1'b1;
                    noadv_d = 1'b1;
                end else begin
                    dout_d  = busBramIn;
                    noadv_d = 1'b0;
                end
            end
            PRESENT: begin
                if (stb_s) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                if (!noadv_q && rd_cnt_q != DEPTH) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A rewind wins over the pending increment of the in-flight byte.
        if (rdRewind) begin
            rd_cnt_d = '0;
            uf_d     = 1'b0;
            if (state_q == FETCH || state_q == PRESENT) begin
                noadv_d = 1'b1;
            end
        end
    end

    assign eppWait     = (state_q == PRESENT);
    assign dataOe      = (state_q == PRESENT);
    assign busy        = (state_q != IDLE);
    assign dataOut     = dout_q;
    assign rdCount     = rd_cnt_q;
    assign underflow   = uf_q;
    assign busBramAddr = rd_cnt_q[ADDR_W-1:0];

endmodule
